quiz_round_controller: RTL

Host-side controller for the fastest-finger-first buzzer arbiter. It owns the arbiter's reset, arms each round on a host command, and consumes the arbiter's latched winner flags. It then runs an answer window, applies the host's judgement to per-player scores, and declares the game winner. It sits between the host/judge console and the `fastest_finger_first` arbiter, as the consumer of the arbiter's winner outputs.

---
 rtl/quiz_pkg.sv | 20 ++
 rtl/quiz_round_controller_if.sv | 29 ++
 rtl/quiz_answer_timer.sv | 22 ++
 rtl/quiz_round_controller.sv | 121 ++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared types for the quiz round controller: FSM states, one-hot player codes
// and the answer timer width.
package quiz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARMED,
        ANSWER,
        DONE,
        OVER
    } state_t;

    localparam logic [1:0] USER_NONE = 2'b00;
    localparam logic [1:0] USER1     = 2'b01;
    localparam logic [1:0] USER2     = 2'b10;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/quiz_round_controller_if.sv
// Host/arbiter-facing signal bundle of the quiz round controller.
// master = host/judge console side, slave = controller side.
interface quiz_round_controller_if #(
    parameter int SCORE_W = 4
);
    logic               start_round;
    logic               winner_user1;
    logic               winner_user2;
    logic               judge_correct;
    logic               judge_wrong;
    logic               arb_rst;
    logic               armed;
    logic [1:0]         answering;
    logic [15:0]        timer;
    logic [SCORE_W-1:0] score_user1;
    logic [SCORE_W-1:0] score_user2;
    logic               game_over;
    logic               err;

    modport master (
        output start_round, winner_user1, winner_user2, judge_correct, judge_wrong,
        input  arb_rst, armed, answering, timer, score_user1, score_user2, game_over, err
    );

    modport slave (
        input  start_round, winner_user1, winner_user2, judge_correct, judge_wrong,
        output arb_rst, armed, answering, timer, score_user1, score_user2, game_over, err
    );
endinterface

// File: rtl/quiz_answer_timer.sv
// Loadable 16-bit down-counter for the answer window; zero flags expiry.
module quiz_answer_timer
    import quiz_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    always_ff @(posedge clk) begin
        if (!rst)      count <= '0;
        else if (load) count <= load_val;
        else if (en)   count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/quiz_round_controller.sv
// Round controller for the fastest-finger-first arbiter: arms rounds, runs the
// answer window, scores verdicts. Optional macro: QUIZ_WRONG_PENALTY_EN.
module quiz_round_controller
    import quiz_pkg::*;
#(
    parameter int ANSWER_CYCLES = 50,
    parameter int SCORE_W       = 4,
    parameter int TARGET_SCORE  = 5
) (
    input logic clk,
    input logic rst,
    quiz_round_controller_if.slave bus
);

    localparam logic [SCORE_W-1:0] TGT     = SCORE_W'(TARGET_SCORE);
    localparam logic [SCORE_W-1:0] MAX_SC  = '1;
    localparam logic [TIMER_W-1:0] WIN_TOP = TIMER_W'(ANSWER_CYCLES - 1);

    state_t             state;
    logic               arb_rst_q, armed_q, game_over_q, err_q;
    logic [1:0]         answering_q;
    logic [SCORE_W-1:0] s1_q, s2_q;

    logic               t_load, t_en, t_zero;
    logic [TIMER_W-1:0] t_load_val, t_count;

    logic one_winner, both_winners, verdict_ok, verdict_bad, answer_exit;

    assign one_winner   = bus.winner_user1 ^ bus.winner_user2;
    assign both_winners = bus.winner_user1 & bus.winner_user2;
    // judge_wrong dominates; a verdict beats a simultaneous timeout
    assign verdict_ok   = bus.judge_correct & ~bus.judge_wrong;
    assign verdict_bad  = bus.judge_wrong | (t_zero & ~bus.judge_correct);
    assign answer_exit  = (state == ANSWER) & (verdict_ok | verdict_bad);

    // Load the window on entry, clear it on exit so timer reads 0 outside ANSWER
    assign t_load     = ((state == ARMED) & one_winner) | answer_exit;
    assign t_load_val = answer_exit ? '0 : WIN_TOP;
    assign t_en       = (state == ANSWER) & ~t_zero;

    quiz_answer_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_load_val),
        .en       (t_en),
        .count    (t_count),
        .zero     (t_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            arb_rst_q   <= 1'b1;
            armed_q     <= 1'b0;
            answering_q <= USER_NONE;
            s1_q        <= '0;
            s2_q        <= '0;
            game_over_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_round) state <= CLEAR;
                CLEAR: begin
                    state     <= ARMED;
                    arb_rst_q <= 1'b0;
                    armed_q   <= 1'b1;
                end
                ARMED: begin
                    if (one_winner) begin
                        state       <= ANSWER;
                        armed_q     <= 1'b0;
                        answering_q <= bus.winner_user1 ? USER1 : USER2;
                    end else if (both_winners) begin
                        state     <= IDLE;
                        armed_q   <= 1'b0;
                        arb_rst_q <= 1'b1;
                        err_q     <= 1'b1;
                    end
                end
                ANSWER: begin
                    if (verdict_ok | verdict_bad) begin
                        state       <= DONE;
                        arb_rst_q   <= 1'b1;
                        answering_q <= USER_NONE;
                    end
                    if (verdict_ok) begin
                        if (answering_q == USER1 && s1_q != MAX_SC) s1_q <= s1_q + 1'b1;
                        if (answering_q == USER2 && s2_q != MAX_SC) s2_q <= s2_q + 1'b1;
                    end
`ifdef QUIZ_WRONG_PENALTY_EN
                    else if (verdict_bad) begin
                        if (answering_q == USER1 && s1_q != '0) s1_q <= s1_q - 1'b1;
                        if (answering_q == USER2 && s2_q != '0) s2_q <= s2_q - 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (s1_q >= TGT || s2_q >= TGT) begin
                        state       <= OVER;
                        game_over_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                OVER:    state <= OVER;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.arb_rst     = arb_rst_q;
    assign bus.armed       = armed_q;
    assign bus.answering   = answering_q;
    assign bus.timer       = t_count;
    assign bus.score_user1 = s1_q;
    assign bus.score_user2 = s2_q;
    assign bus.game_over   = game_over_q;
    assign bus.err         = err_q;

endmodule
